pipeline_control_unit: RTL and testbench

Central stall/flush sequencer for the 5-stage ARMv8 pipeline (IF, ID, EX, MEM, WB). Merges the load-use stall request, the EX-stage taken-branch indication and the instruction/data memory busy signals into per-stage write-enable and flush controls. Also drives the PC-source select. It owns the only FSM that freezes or flushes pipeline registers; the hazard detector only requests stalls.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_perf_counter.sv | 23 ++
 rtl/pipeline_control_unit.sv | 177 +++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM encodings, parameter
// defaults and the RUN-state request priority encoder.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StFlush   = 2'd2
   } ctrl_state_e;

   localparam int unsigned DefBranchPenalty = 1;
   localparam int unsigned DefMemTimeout    = 15;
   localparam int unsigned DefCntW          = 16;

   // Enumerators are ordered by ascending priority.
   typedef enum logic [2:0] {
      ReqNone    = 3'd0,
      ReqImem    = 3'd1,
      ReqLoadUse = 3'd2,
      ReqBranch  = 3'd3,
      ReqDmem    = 3'd4
   } req_e;

   function automatic req_e run_request(input logic dmem_busy, input logic branch_taken,
                                        input logic load_use_stall, input logic imem_busy);
      if (dmem_busy) return ReqDmem;
      if (branch_taken) return ReqBranch;
      if (load_use_stall) return ReqLoadUse;
      if (imem_busy) return ReqImem;
      return ReqNone;
   endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating event counter used for the optional pipeline performance statistics.
module pipe_perf_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline; outputs are combinational from state
// and inputs. Define PIPE_CTRL_PERF_EN to add the stall/flush/memwait cycle counters.
module pipeline_control_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned BRANCH_PENALTY = DefBranchPenalty,
   parameter int unsigned MEM_TIMEOUT    = DefMemTimeout,
   parameter int unsigned CNT_W          = DefCntW
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load_use_stall,
   input  logic       branch_taken,
   input  logic       imem_busy,
   input  logic       dmem_busy,
   output logic       pc_write,
   output logic       pc_src_branch,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_write,
   output logic       id_ex_flush,
   output logic       ex_mem_write,
   output logic       mem_wb_bubble,
   output logic       mem_timeout,
   output logic [1:0] ctrl_state
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles,
   output logic [CNT_W-1:0] memwait_cycles
`endif
);

   ctrl_state_e state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic        pending_q, pending_d;
   logic        timeout_q, timeout_d;
   req_e        req;
   logic        run_stall;

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      pending_d     = pending_q;
      timeout_d     = timeout_q;
      pc_write      = 1'b1;
      pc_src_branch = 1'b0;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_bubble = 1'b0;
      req           = ReqNone;

      unique case (state_q)
         StRun: req = run_request(dmem_busy, branch_taken, load_use_stall, imem_busy);
         // EX is frozen here, so a live branch_taken only repeats what was latched on entry.
         StMemWait: begin
            if (dmem_busy) req = ReqDmem;
            else if (pending_q) req = ReqBranch;
            else req = run_request(1'b0, 1'b0, load_use_stall, imem_busy);
         end
         StFlush: req = dmem_busy ? ReqDmem : ReqNone;
         default: req = ReqNone;
      endcase

      if ((state_q == StFlush) && !dmem_busy) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         pc_write    = !imem_busy;
         if (!imem_busy) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q <= 3'd1) state_d = StRun;
         end
      end else begin
         unique case (req)
            ReqDmem: begin
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               id_ex_write   = 1'b0;
               ex_mem_write  = 1'b0;
               mem_wb_bubble = 1'b1;
               state_d       = StMemWait;
               if (state_q == StMemWait) begin
                  wait_cnt_d = (wait_cnt_q == 8'hff) ? wait_cnt_q : wait_cnt_q + 8'd1;
               end else begin
                  wait_cnt_d = 8'd1;
                  pending_d  = (state_q == StRun) && branch_taken;
               end
            end
            ReqBranch: begin
               pc_src_branch = 1'b1;
               if_id_flush   = 1'b1;
               id_ex_flush   = 1'b1;
               pending_d     = 1'b0;
               if (BRANCH_PENALTY > 1) begin
                  state_d     = StFlush;
                  flush_cnt_d = 3'(BRANCH_PENALTY - 1);
               end else begin
                  state_d = StRun;
               end
            end
            ReqLoadUse, ReqImem: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               state_d     = StRun;
            end
            default: state_d = StRun;
         endcase
      end

      if ((req == ReqDmem) && (wait_cnt_d >= 8'(MEM_TIMEOUT))) timeout_d = 1'b1;

      if (reset) begin
         pc_write      = 1'b0;
         pc_src_branch = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_write   = 1'b0;
         id_ex_flush   = 1'b1;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end
   end

   assign run_stall = (state_q == StRun) && ((req == ReqLoadUse) || (req == ReqImem));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         flush_cnt_q <= '0;
         pending_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         pending_q   <= pending_d;
         timeout_q   <= timeout_d;
      end
   end

   assign mem_timeout = timeout_q & ~reset;
   assign ctrl_state  = state_q;

`ifdef PIPE_CTRL_PERF_EN
   pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (run_stall),
      .count (stall_cycles)
   );

   pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (if_id_flush),
      .count (flush_cycles)
   );

   pipe_perf_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (state_q == StMemWait),
      .count (memwait_cycles)
   );
`else
   logic unused_run_stall;
   assign unused_run_stall = run_stall;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Vector-table bench for pipeline_control_unit (BRANCH_PENALTY=3, MEM_TIMEOUT=15, CNT_W=4);
// expected output words are queued at drive time and popped at the falling edge.
module tb_pipeline_control_unit;

   logic       clock;
   logic       reset;
   logic       load_use_stall, branch_taken, imem_busy, dmem_busy;
   logic       pc_write, pc_src_branch, if_id_write, if_id_flush;
   logic       id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble, mem_timeout;
   logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
   logic [3:0] stall_cycles, flush_cycles, memwait_cycles;
`endif

   pipeline_control_unit #(
      .BRANCH_PENALTY (3),
      .MEM_TIMEOUT    (15),
      .CNT_W          (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .load_use_stall (load_use_stall),
      .branch_taken   (branch_taken),
      .imem_busy      (imem_busy),
      .dmem_busy      (dmem_busy),
      .pc_write       (pc_write),
      .pc_src_branch  (pc_src_branch),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush),
      .id_ex_write    (id_ex_write),
      .id_ex_flush    (id_ex_flush),
      .ex_mem_write   (ex_mem_write),
      .mem_wb_bubble  (mem_wb_bubble),
      .mem_timeout    (mem_timeout),
      .ctrl_state     (ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cycles   (stall_cycles),
      .flush_cycles   (flush_cycles),
      .memwait_cycles (memwait_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Output word: pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
   // ex_mem_write, mem_wb_bubble, mem_timeout, ctrl_state[1:0]
   localparam logic [10:0] ERst   = 11'b0_0_0_1_0_1_0_1_0_00;
   localparam logic [10:0] EIdle  = 11'b1_0_1_0_1_0_1_0_0_00;
   localparam logic [10:0] EStall = 11'b0_0_0_0_1_1_1_0_0_00;
   localparam logic [10:0] EBr    = 11'b1_1_1_1_1_1_1_0_0_00;
   localparam logic [10:0] EFl    = 11'b1_0_1_1_1_1_1_0_0_10;
   localparam logic [10:0] EFlB   = 11'b0_0_1_1_1_1_1_0_0_10;
   localparam logic [10:0] EFrz   = 11'b0_0_0_0_0_0_0_1_0_00;
   localparam logic [10:0] StMw   = 11'b0_0_0_0_0_0_0_0_0_01;
   localparam logic [10:0] StFl   = 11'b0_0_0_0_0_0_0_0_0_10;
   localparam logic [10:0] To     = 11'b0_0_0_0_0_0_0_0_1_00;

   typedef struct {
      string       name;
      logic        rst, lu, br, ib, db;
      logic [10:0] exp;
      int          chk_stall;
   } vec_t;

   vec_t        vecs[$];
   logic [10:0] exp_q[$];
   string       name_q[$];
   int          total = 0;
   int          bad = 0;

   task automatic add(input string name, input logic rst, input logic lu, input logic br,
                      input logic ib, input logic db, input logic [10:0] exp,
                      input int chk_stall = -1);
      vec_t v;
      v.name = name; v.rst = rst; v.lu = lu; v.br = br; v.ib = ib; v.db = db;
      v.exp = exp; v.chk_stall = chk_stall;
      vecs.push_back(v);
   endtask

   initial begin
      logic [10:0] got, want;
      string       nm;

      reset = 1'b1; load_use_stall = 1'b1; branch_taken = 1'b1;
      imem_busy = 1'b1; dmem_busy = 1'b1;

      for (int i = 0; i < 3; i++) add("reset_hold", 1, 1, 1, 1, 1, ERst);
      add("first_idle", 0, 0, 0, 0, 0, EIdle);
      add("load_use", 0, 1, 0, 0, 0, EStall);
      add("after_lu", 0, 0, 0, 0, 0, EIdle);
      add("imem_only", 0, 0, 0, 1, 0, EStall);
      add("lu_imem", 0, 1, 0, 1, 0, EStall);
      add("br_lu", 0, 1, 1, 0, 0, EBr);
      add("flush2", 0, 0, 0, 0, 0, EFl);
      add("flush3", 0, 0, 0, 0, 0, EFl);
      add("post_flush", 0, 0, 0, 0, 0, EIdle);
      add("br2", 0, 0, 1, 0, 0, EBr);
      add("flush_imem", 0, 0, 0, 1, 0, EFlB);
      add("flush_b3", 0, 0, 0, 0, 0, EFl);
      add("flush_b4", 0, 0, 0, 0, 0, EFl);
      add("post_flush_b", 0, 0, 0, 0, 0, EIdle);
      add("br_dmem", 0, 0, 1, 0, 1, EFrz);
      add("mw2", 0, 0, 0, 0, 1, EFrz | StMw);
      add("mw3_br_ign", 0, 0, 1, 0, 1, EFrz | StMw);
      add("mw4", 0, 0, 0, 0, 1, EFrz | StMw);
      add("mw_drop_br", 0, 0, 0, 0, 0, EBr | StMw);
      add("mw_flush2", 0, 0, 0, 0, 0, EFl);
      add("mw_flush3", 0, 0, 0, 0, 0, EFl);
      add("mw_done", 0, 0, 0, 0, 0, EIdle);
      add("dmem_nobr", 0, 0, 0, 0, 1, EFrz);
      add("mw_drop_lu", 0, 1, 0, 0, 0, EStall | StMw);
      add("run_again", 0, 0, 0, 0, 0, EIdle);
      add("br_fl_dmem", 0, 0, 1, 0, 0, EBr);
      add("flush_dmem", 0, 0, 0, 0, 1, EFrz | StFl);
      add("mw_drop_idle", 0, 0, 0, 0, 0, EIdle | StMw);
      add("idle_after", 0, 0, 0, 0, 0, EIdle);
      add("br_then_rst", 0, 0, 1, 0, 0, EBr);
      add("rst_in_flush", 1, 0, 0, 0, 0, ERst | StFl);
      add("rst_abandon", 0, 0, 0, 0, 0, EIdle);

      // 20 busy cycles: counter reaches 15 on busy cycle 15, flag visible from cycle 16
      add("to_busy1", 0, 0, 0, 0, 1, EFrz);
      for (int k = 2; k <= 20; k++)
         add($sformatf("to_busy%0d", k), 0, 0, 0, 0, 1, EFrz | StMw | ((k >= 16) ? To : '0));
      add("to_drop", 0, 0, 0, 0, 0, EIdle | StMw | To);
      add("to_sticky", 0, 0, 0, 0, 0, EIdle | To);
      add("to_sticky_lu", 0, 1, 0, 0, 0, EStall | To);
      add("to_rst", 1, 0, 0, 0, 0, ERst);
      add("to_cleared", 0, 0, 0, 0, 0, EIdle);

      // Saturating stall counter: value seen at cycle n's falling edge counts n-1 stalls
      add("perf_rst", 1, 0, 0, 0, 0, ERst);
      for (int k = 1; k <= 20; k++)
         add($sformatf("perf_lu%0d", k), 0, 1, 0, 0, 0, EStall, (k == 6) ? 5 : -1);
      add("perf_sat", 0, 0, 0, 0, 0, EIdle, 15);

      foreach (vecs[i]) begin
         @(posedge clock);
         #1;
         reset = vecs[i].rst; load_use_stall = vecs[i].lu; branch_taken = vecs[i].br;
         imem_busy = vecs[i].ib; dmem_busy = vecs[i].db;
         exp_q.push_back(vecs[i].exp);
         name_q.push_back(vecs[i].name);
         @(negedge clock);
         got = {pc_write, pc_src_branch, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_write, mem_wb_bubble, mem_timeout, ctrl_state};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %b with no expected entry", got);
         end else begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            if (got !== want) begin
               bad++;
               $display("FAIL %s: got %b want %b", nm, got, want);
            end
         end
`ifdef PIPE_CTRL_PERF_EN
         if (vecs[i].chk_stall >= 0) begin
            total++;
            if (int'(stall_cycles) != vecs[i].chk_stall) begin
               bad++;
               $display("FAIL %s_stall_cycles: got %0d want %0d", vecs[i].name, stall_cycles,
                        vecs[i].chk_stall);
            end
         end
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
